clock_time_ctrl: RTL

Timekeeping controller for the board clock. It consumes the 1 Hz square wave from the second divider and advances an hh:mm:ss BCD time-of-day register. A small mode FSM lets the user set hours and minutes with two debounced keys. Outputs drive the display/scan logic downstream.

---
 rtl/clock_time_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: 1 Hz edge-driven hh:mm:ss BCD counter with a set-hour/set-minute mode FSM.
// Optional alarm comparator is enabled by defining ALARM_EN.
module clock_time_ctrl #(
    parameter int HOUR_MAX = 23
) (
    input  logic       Clk_50MHz,
    input  logic       Reset_N,
    input  logic       Second_in,
    input  logic       Key_mode,
    input  logic       Key_inc,
    output logic [7:0] Hour_bcd,
    output logic [7:0] Min_bcd,
    output logic [7:0] Sec_bcd,
    output logic [1:0] Mode,
    output logic       Blink,
    output logic       Day_pulse
`ifdef ALARM_EN
    ,
    input  logic [7:0] Alarm_hour,
    input  logic [7:0] Alarm_min,
    output logic       Alarm_out
`endif
);

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] SET_HOUR = 2'b01;
    localparam logic [1:0] SET_MIN  = 2'b10;

    localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

    logic sec_d;
    logic mode_d;
    logic inc_d;
    logic tick;
    logic mode_ev;
    logic inc_ev;

    assign tick    = Second_in & ~sec_d;
    assign mode_ev = Key_mode & ~mode_d;
    assign inc_ev  = Key_inc & ~inc_d;

    // Two-digit BCD increment that wraps to 00 after maxv.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return v + 8'd1;
    endfunction

    always_ff @(posedge Clk_50MHz) begin
        if (!Reset_N) begin
            sec_d     <= 1'b0;
            mode_d    <= 1'b0;
            inc_d     <= 1'b0;
            Hour_bcd  <= 8'h00;
            Min_bcd   <= 8'h00;
            Sec_bcd   <= 8'h00;
            Mode      <= RUN;
            Blink     <= 1'b0;
            Day_pulse <= 1'b0;
        end else begin
            sec_d     <= Second_in;
            mode_d    <= Key_mode;
            inc_d     <= Key_inc;
            Day_pulse <= 1'b0;
            Blink     <= (Mode != RUN) & Second_in;

            case (Mode)
                RUN: begin
                    // A tick coinciding with a mode event is still counted.
                    if (tick) begin
                        if (Sec_bcd == MIN_MAX_BCD) begin
                            Sec_bcd <= 8'h00;
                            if (Min_bcd == MIN_MAX_BCD) begin
                                Min_bcd <= 8'h00;
                                if (Hour_bcd == HOUR_MAX_BCD) begin
                                    Hour_bcd  <= 8'h00;
                                    Day_pulse <= 1'b1;
                                end else begin
                                    Hour_bcd <= bcd_next(Hour_bcd, HOUR_MAX_BCD);
                                end
                            end else begin
                                Min_bcd <= bcd_next(Min_bcd, MIN_MAX_BCD);
                            end
                        end else begin
                            Sec_bcd <= bcd_next(Sec_bcd, MIN_MAX_BCD);
                        end
                    end
                    if (mode_ev)
                        Mode <= SET_HOUR;
                end
                SET_HOUR: begin
                    if (mode_ev)
                        Mode <= SET_MIN;
                    else if (inc_ev)
                        Hour_bcd <= bcd_next(Hour_bcd, HOUR_MAX_BCD);
                end
                SET_MIN: begin
                    if (mode_ev) begin
                        Mode    <= RUN;
                        Sec_bcd <= 8'h00;
                    end else if (inc_ev) begin
                        Min_bcd <= bcd_next(Min_bcd, MIN_MAX_BCD);
                    end
                end
                default: Mode <= RUN;
            endcase
        end
    end

`ifdef ALARM_EN
    always_ff @(posedge Clk_50MHz) begin
        if (!Reset_N)
            Alarm_out <= 1'b0;
        else
            Alarm_out <= (Mode == RUN) && (Hour_bcd == Alarm_hour) && (Min_bcd == Alarm_min);
    end
`endif

endmodule
